// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with per-register pending-write counters and writeback bypass
// Ports: clk, rst (sync, active-high)
//   issue_valid/issue_ready, rs1_addr/rs2_addr, rs1_used/rs2_used, rd_addr, rd_write : decode handshake
//   rs1_data/rs2_data : combinational operand reads (x0 reads 0, same-cycle writeback bypassed)
//   wb_en/wb_addr/wb_data : writeback commit port
//   flush : clears all pending counters, register contents kept
//   stall_cycles : saturating count of cycles with issue_valid && !issue_ready
module regfile_scoreboard #(
    parameter int XLEN   = 64,
    parameter int PEND_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic [4:0]      rd_addr,
    input  logic            rd_write,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic [31:0]     stall_cycles
);
    logic [XLEN-1:0]   regs [32];
    logic [PEND_W-1:0] pend [32];
    logic [PEND_W-1:0] p1, p2;
    logic              rs1_ok, rs2_ok, rd_ok, fire;
    // A source is clear once its effective count (pending minus this cycle's commit) reaches zero.
    // The destination limit uses the raw count, so a full register stays blocked even while committing.
    always_comb begin
        p1          = pend[rs1_addr];
        p2          = pend[rs2_addr];
        rs1_ok      = !rs1_used || rs1_addr == 5'd0 || p1 == '0 ||
                      (p1 == PEND_W'(1) && wb_en && wb_addr == rs1_addr);
        rs2_ok      = !rs2_used || rs2_addr == 5'd0 || p2 == '0 ||
                      (p2 == PEND_W'(1) && wb_en && wb_addr == rs2_addr);
        rd_ok       = !rd_write || rd_addr == 5'd0 || pend[rd_addr] != '1;
        issue_ready = rs1_ok && rs2_ok && rd_ok;
        fire        = issue_valid && issue_ready;
        rs1_data    = rs1_addr == 5'd0 ? '0 : (wb_en && wb_addr == rs1_addr) ? wb_data : regs[rs1_addr];
        rs2_data    = rs2_addr == 5'd0 ? '0 : (wb_en && wb_addr == rs2_addr) ? wb_data : regs[rs2_addr];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
                pend[i] <= '0;
            end
            stall_cycles <= '0;
        end else begin
            if (wb_en && wb_addr != 5'd0)
                regs[wb_addr] <= wb_data;
            if (issue_valid && !issue_ready && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            for (int i = 1; i < 32; i++)
                pend[i] <= flush ? '0 :
                           pend[i] + PEND_W'(fire && rd_write && rd_addr == 5'(i))
                                   - PEND_W'(wb_en && wb_addr == 5'(i) && pend[i] != '0);
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vector table plus hand sequences for pending limits, flush, stall saturation and reset
module tb_regfile_scoreboard;
    logic        clk, rst, issue_valid, issue_ready;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, wb_addr;
    logic        rs1_used, rs2_used, rd_write, wb_en, flush;
    logic [63:0] rs1_data, rs2_data, wb_data;
    logic [31:0] stall_cycles;
    int          n_chk = 0;
    int          n_fail = 0;

    regfile_scoreboard #(.XLEN(64), .PEND_W(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_addr(rd_addr), .rd_write(rd_write),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          iv, a1, u1, a2, u2, rd, rw, wb, wa;
        logic [63:0] wd;
        int          fl, rdy;
        logic [63:0] d1, d2;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input int iv, input int a1, input int u1, input int a2, input int u2,
                       input int rd, input int rw, input int wb, input int wa,
                       input logic [63:0] wd, input int fl);
        issue_valid = 1'(iv);
        rs1_addr    = 5'(a1);
        rs1_used    = 1'(u1);
        rs2_addr    = 5'(a2);
        rs2_used    = 1'(u2);
        rd_addr     = 5'(rd);
        rd_write    = 1'(rw);
        wb_en       = 1'(wb);
        wb_addr     = 5'(wa);
        wb_data     = wd;
        flush       = 1'(fl);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          iv a1 u1 a2 u2 rd rw wb wa  wd            fl rdy d1            d2
        vt[0]  = '{1, 5, 1, 0, 1, 7, 1, 0, 0, 64'h0,        0, 1, 64'h0,        64'h0};
        vt[1]  = '{1, 7, 1, 0, 0, 0, 0, 0, 0, 64'h0,        0, 0, 64'h0,        64'h0};
        vt[2]  = '{1, 7, 1, 0, 0, 0, 0, 1, 7, 64'h11,       0, 1, 64'h11,       64'h0};
        vt[3]  = '{1, 7, 1, 0, 0, 3, 1, 0, 0, 64'h0,        0, 1, 64'h11,       64'h0};
        vt[4]  = '{1, 3, 1, 0, 0, 0, 0, 0, 0, 64'h0,        0, 0, 64'h0,        64'h0};
        vt[5]  = '{1, 3, 1, 0, 0, 0, 0, 0, 0, 64'h0,        0, 0, 64'h0,        64'h0};
        vt[6]  = '{1, 3, 1, 0, 0, 0, 0, 1, 3, 64'hDEADBEEF, 0, 1, 64'hDEADBEEF, 64'h0};
        vt[7]  = '{1, 3, 1, 3, 1, 0, 0, 0, 0, 64'h0,        0, 1, 64'hDEADBEEF, 64'hDEADBEEF};
        vt[8]  = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 64'h1234,     0, 1, 64'h0,        64'h0};
        vt[9]  = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 64'h0,        0, 1, 64'h0,        64'h0};
        vt[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 64'h0,        0, 1, 64'h0,        64'h0};

        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0);
        step();
        step();
        rst = 1'b0;

        drv(0, 5, 1, 9, 1, 31, 1, 0, 0, 64'h0, 0);
        chk("reset_ready", issue_ready, 1);
        chk("reset_rs1_x5", rs1_data, 0);
        chk("reset_rs2_x9", rs2_data, 0);
        chk("reset_stall", stall_cycles, 0);
        drv(0, 0, 1, 0, 1, 0, 0, 0, 0, 64'h0, 0);
        chk("reset_rs1_x0", rs1_data, 0);

        for (int k = 0; k < 11; k++) begin
            drv(vt[k].iv, vt[k].a1, vt[k].u1, vt[k].a2, vt[k].u2, vt[k].rd, vt[k].rw,
                vt[k].wb, vt[k].wa, vt[k].wd, vt[k].fl);
            chk($sformatf("vec%0d_ready", k), issue_ready, 64'(vt[k].rdy));
            chk($sformatf("vec%0d_rs1", k), rs1_data, vt[k].d1);
            chk($sformatf("vec%0d_rs2", k), rs2_data, vt[k].d2);
            step();
            if (k == 0) chk("pend7_after_fire", dut.pend[7], 1);
        end
        chk("table_stall", stall_cycles, 3);
        chk("table_pend3", dut.pend[3], 0);
        chk("table_pend7", dut.pend[7], 0);

        for (int k = 0; k < 3; k++) begin
            drv(1, 0, 0, 0, 0, 9, 1, 0, 0, 64'h0, 0);
            chk($sformatf("rd9_issue%0d_ready", k), issue_ready, 1);
            step();
        end
        chk("pend9_full", dut.pend[9], 3);
        drv(1, 0, 0, 0, 0, 9, 1, 0, 0, 64'h0, 0);
        chk("rd9_blocked", issue_ready, 0);
        step();
        drv(1, 0, 0, 0, 0, 9, 1, 1, 9, 64'h99, 0);
        chk("rd9_blocked_during_wb", issue_ready, 0);
        step();
        chk("pend9_after_wb", dut.pend[9], 2);
        drv(1, 0, 0, 0, 0, 9, 1, 1, 9, 64'h9A, 0);
        chk("rd9_fire_with_wb", issue_ready, 1);
        step();
        chk("pend9_inc_dec", dut.pend[9], 2);
        drv(1, 9, 1, 0, 0, 0, 0, 1, 9, 64'hA, 0);
        chk("rs9_eff1_ready", issue_ready, 0);
        chk("rs9_bypass", rs1_data, 64'hA);
        step();
        drv(1, 9, 1, 0, 0, 0, 0, 1, 9, 64'hB, 0);
        chk("rs9_eff0_ready", issue_ready, 1);
        chk("rs9_bypass_last", rs1_data, 64'hB);
        step();
        chk("pend9_drained", dut.pend[9], 0);
        chk("seqA_stall", stall_cycles, 6);

        drv(1, 0, 0, 0, 0, 4, 1, 0, 0, 64'h0, 0);
        step();
        drv(1, 0, 0, 0, 0, 6, 1, 0, 0, 64'h0, 0);
        step();
        chk("pend4_reserved", dut.pend[4], 1);
        chk("pend6_reserved", dut.pend[6], 1);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 4, 64'h55, 1);
        step();
        chk("flush_pend4", dut.pend[4], 0);
        chk("flush_pend6", dut.pend[6], 0);
        drv(1, 4, 1, 6, 1, 0, 0, 1, 6, 64'h77, 0);
        chk("post_flush_ready", issue_ready, 1);
        chk("flush_wb_data_x4", rs1_data, 64'h55);
        chk("x6_bypass", rs2_data, 64'h77);
        step();
        chk("pend6_no_underflow", dut.pend[6], 0);
        drv(0, 0, 0, 6, 1, 0, 0, 0, 0, 64'h0, 0);
        chk("x6_array", rs2_data, 64'h77);
        chk("seqB_stall", stall_cycles, 6);

        drv(1, 0, 0, 0, 0, 10, 1, 0, 0, 64'h0, 0);
        step();
        drv(1, 10, 1, 0, 0, 0, 0, 0, 0, 64'h0, 0);
        chk("rs10_stall_ready", issue_ready, 0);
        dut.stall_cycles = 32'hFFFFFFFE;
        step();
        chk("stall_reach_max", stall_cycles, 32'hFFFFFFFF);
        step();
        chk("stall_hold_max", stall_cycles, 32'hFFFFFFFF);
        rst = 1'b1;
        drv(1, 10, 1, 0, 0, 11, 1, 1, 4, 64'h66, 1);
        step();
        rst = 1'b0;
        drv(1, 10, 1, 4, 1, 10, 1, 0, 0, 64'h0, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_pend10", dut.pend[10], 0);
        chk("rst_pend11", dut.pend[11], 0);
        chk("rst_ready", issue_ready, 1);
        chk("rst_x4_cleared", rs2_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Integer register file with in-flight write tracking. Decode uses it to read operands and to reserve destination registers. The writeback stage uses it to commit results. Each architectural register has a per-register pending counter, and decode is held whenever a source operand still has an outstanding write. A same-cycle writeback is bypassed into the read ports, so a dependent instruction issues in the cycle its producer commits.

## Interface

Parameters:
- XLEN, 64, register and data width
- PEND_W, 2, width of each per-register pending counter; maximum in-flight writes per register is 2^PEND_W-1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  scoreboard accepts it; depends only on state, address and use inputs, never on issue_valid
- rs1_addr, rs2_addr  in  5  source register indices
- rs1_used, rs2_used  in  1  instruction actually reads that source
- rd_addr  in  5  destination index
- rd_write  in  1  instruction will write rd
- rs1_data, rs2_data  out  XLEN  operand values, combinational
- wb_en  in  1  writeback commits a result this cycle
- wb_addr  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- flush  in  1  pipeline redirect; clears all pending counters
- stall_cycles  out  32  count of cycles with issue_valid && !issue_ready, saturating

## Operation

- Storage: 31 registers x XLEN, indices 1..31. x0 reads 0. Writes to x0 are dropped. x0 is never pending.
- Write port: when wb_en && wb_addr!=0, regs[wb_addr] <= wb_data at the clock edge.
- Read ports: rsN_data = 0 if rsN_addr==0. Otherwise it is wb_data if wb_en && wb_addr==rsN_addr. Otherwise it is regs[rsN_addr].
- Pending counter pend[i], for i=1..31:
  - dec_i = wb_en && wb_addr==i && pend[i]!=0
  - inc_i = fire && rd_write && rd_addr==i, where fire = issue_valid && issue_ready
  - Next value is pend[i] + inc_i - dec_i. If inc and dec hit the same register in one cycle, the counter is unchanged.
  - A writeback to a register whose counter is 0 still writes data. The counter stays 0 and never underflows.
- Effective pending: eff[i] = pend[i] - dec_i.
- issue_ready is 1 only if all three hold:
  - rs1_used is 0, or rs1_addr==0, or eff[rs1_addr]==0
  - rs2_used is 0, or rs2_addr==0, or eff[rs2_addr]==0
  - rd_write is 0, or rd_addr==0, or pend[rd_addr] is below the maximum
- flush: all pend <= 0. flush takes priority over inc and dec in the same cycle. A writeback in the flush cycle still writes data. Register contents are never cleared by flush.
- Stall counter: increments when issue_valid && !issue_ready and stall_cycles is below 0xFFFFFFFF. It holds at 0xFFFFFFFF and is not affected by flush.

## Timing

- Reset, synchronous: all regs 0, all pend 0, stall_cycles 0. After reset, issue_ready=1 for any input combination, and rs1_data/rs2_data read 0.
- Read latency is 0 cycles, combinational from address. A write committed at edge N is visible through the array from cycle N+1, and through the bypass during cycle N.
- Producer-consumer: if the producer's wb_en occurs in cycle N, a consumer held at decode sees issue_ready=1 in cycle N with the bypassed value.
- A reservation made by a fire at edge N affects issue_ready from cycle N+1.
- rst asserted mid-operation overrides flush, wb_en and fire. All state returns to its reset values at that edge.
- Counter wrap is impossible: issue is blocked at the maximum count.

## Test plan

- Reset, then read x5 and x0 -> both 0. Set issue_valid=1 with rs1=5, rs2=0, rd=7 -> issue_ready=1. Next cycle, pend[7]=1.
- Issue rd=3 (fire). Next cycle, issue rs1=3, rs1_used=1 -> issue_ready=0 and stall_cycles increments each cycle. Then wb_en=1, wb_addr=3, wb_data=0xDEADBEEF -> issue_ready=1 in the same cycle and rs1_data=0xDEADBEEF. Next cycle, pend[3]=0.
- wb_en=1, wb_addr=0, wb_data=0x1234 -> the following read of x0 returns 0. Issue rd=0 -> no reservation; rs1=0 never stalls.
- Issue rd=9 three times with PEND_W=2 -> pend[9]=3. A fourth issue with rd=9 -> issue_ready=0. Fire and wb to 9 in the same cycle -> pend[9] stays at its current value.
- Reserve x4 and x6, then assert flush together with wb_en to x4 carrying 0x55 -> all pend=0 and regs[4]=0x55. A later wb to x6 with 0x77 -> data written and pend[6] stays 0.
- Force stall_cycles near saturation by holding a stall for 2^32 cycles, or by a bench backdoor to 0xFFFFFFFE -> stall_cycles reaches 0xFFFFFFFF and holds. Assert rst mid-stall -> stall_cycles=0 and all pend=0 at that edge.
